// File: rtl/sipo_rx_pkg.sv
// Shared definitions for the stepper serial-link receiver and its transmitter counterpart.
// Both ends size their bit counters with count_width so they always agree.
package sipo_rx_pkg;

    typedef enum logic {
        ST_HUNT  = 1'b0,
        ST_SHIFT = 1'b1
    } sipo_state_t;

    // A one-bit counter is still needed for a two-bit word.
    function automatic int count_width(input int size);
        return (size <= 2) ? 1 : $clog2(size);
    endfunction

endpackage

// File: rtl/sipo_out_stage.sv
// One-entry valid/ready holding register for deserialised words.
// A word that completes while the held word is still unaccepted is dropped and flagged as overrun.
module sipo_out_stage #(
    parameter int SIZE = 8
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            load,
    input  logic [SIZE-1:0] load_data,
    input  logic            ready_in,
    input  logic            clear_in,
    output logic [SIZE-1:0] r_data_out,
    output logic            r_valid_out,
    output logic            r_overrun_out
);

    logic accept;
    logic drop;

    assign accept = r_valid_out && ready_in;
    assign drop   = load && r_valid_out && !ready_in;

    // Accept-and-load in the same cycle keeps valid high so words stream without a bubble.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_data_out    <= '0;
            r_valid_out   <= 1'b0;
            r_overrun_out <= 1'b0;
        end else begin
            if (load && (!r_valid_out || ready_in)) begin
                r_data_out  <= load_data;
                r_valid_out <= 1'b1;
            end else if (accept) begin
                r_valid_out <= 1'b0;
            end

            if (drop) begin
                r_overrun_out <= 1'b1;
            end else if (clear_in) begin
                r_overrun_out <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: assembles SIZE bits MSB first into a word,
// optionally aligning on a start-of-word marker and reporting framing errors.
module sipo_rx
    import sipo_rx_pkg::*;
#(
    parameter int SIZE   = 8,
    parameter int FRAMED = 1
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            data_in,
    input  logic            valid_in,
    input  logic            frame_in,
    input  logic            ready_in,
    input  logic            clear_in,
    output logic [SIZE-1:0] r_data_out,
    output logic            r_valid_out,
    output logic            r_overrun_out,
    output logic            r_frame_err_out
);

    localparam int            CW       = count_width(SIZE);
    localparam logic [CW-1:0] LAST     = CW'(SIZE - 1);
    localparam logic [CW-1:0] NEXT_MSB = CW'(SIZE - 2);

    sipo_state_t     state;
    sipo_state_t     state_next;
    logic [SIZE-1:0] shift_reg;
    logic [SIZE-1:0] shift_next;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   count_next;
    logic            frame_hit;
    logic            resync;
    logic            complete;
    logic [SIZE-1:0] word;

    assign frame_hit = (FRAMED != 0) && valid_in && frame_in;

    // The final bit is merged combinationally so the word is presented on the edge that samples it.
    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        count_next = r_count;
        resync     = 1'b0;
        complete   = 1'b0;
        word       = {shift_reg[SIZE-1:1], data_in};

        if (valid_in) begin
            case (state)
                ST_HUNT: begin
                    if (frame_hit) begin
                        shift_next = {data_in, {(SIZE-1){1'b0}}};
                        count_next = NEXT_MSB;
                        state_next = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (frame_hit) begin
                        resync     = (r_count != LAST);
                        shift_next = {data_in, {(SIZE-1){1'b0}}};
                        count_next = NEXT_MSB;
                    end else begin
                        shift_next[r_count] = data_in;
                        if (r_count == '0) begin
                            complete   = 1'b1;
                            count_next = LAST;
                        end else begin
                            count_next = r_count - 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state           <= (FRAMED != 0) ? ST_HUNT : ST_SHIFT;
            shift_reg       <= '0;
            r_count         <= LAST;
            r_frame_err_out <= 1'b0;
        end else begin
            state           <= state_next;
            shift_reg       <= shift_next;
            r_count         <= count_next;
            r_frame_err_out <= resync;
        end
    end

    sipo_out_stage #(
        .SIZE(SIZE)
    ) u_out_stage (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .load          (complete),
        .load_data     (word),
        .ready_in      (ready_in),
        .clear_in      (clear_in),
        .r_data_out    (r_data_out),
        .r_valid_out   (r_valid_out),
        .r_overrun_out (r_overrun_out)
    );

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: framed 8-bit, free-running 8-bit and framed 2-bit receivers share one
// input stream and are checked every cycle against a bit-counting word-level model.
module tb_sipo_rx;
    import sipo_rx_pkg::*;

    logic clk_in = 1'b0;
    logic reset_in;
    logic data_in;
    logic valid_in;
    logic frame_in;
    logic ready_in;
    logic clear_in;

    logic [7:0] f_data;
    logic       f_valid, f_over, f_ferr;
    logic [7:0] r_data;
    logic       r_valid, r_over, r_ferr;
    logic [1:0] s_data;
    logic       s_valid, s_over, s_ferr;

    int test_cnt = 0;
    int fail_cnt = 0;

    // Model state per receiver: 0 = framed SIZE 8, 1 = free-running SIZE 8, 2 = framed SIZE 2.
    int m_size[3]   = '{8, 8, 2};
    bit m_framed[3] = '{1'b1, 1'b0, 1'b1};
    bit m_hunt[3];
    int m_nbits[3];
    int m_acc[3];
    bit m_valid[3];
    int m_data[3];
    bit m_over[3];
    bit m_ferr[3];

    always #5 clk_in = ~clk_in;

    sipo_rx #(.SIZE(8), .FRAMED(1)) dut_f (
        .clk_in(clk_in), .reset_in(reset_in), .data_in(data_in), .valid_in(valid_in),
        .frame_in(frame_in), .ready_in(ready_in), .clear_in(clear_in),
        .r_data_out(f_data), .r_valid_out(f_valid), .r_overrun_out(f_over),
        .r_frame_err_out(f_ferr)
    );

    sipo_rx #(.SIZE(8), .FRAMED(0)) dut_r (
        .clk_in(clk_in), .reset_in(reset_in), .data_in(data_in), .valid_in(valid_in),
        .frame_in(frame_in), .ready_in(ready_in), .clear_in(clear_in),
        .r_data_out(r_data), .r_valid_out(r_valid), .r_overrun_out(r_over),
        .r_frame_err_out(r_ferr)
    );

    sipo_rx #(.SIZE(2), .FRAMED(1)) dut_s (
        .clk_in(clk_in), .reset_in(reset_in), .data_in(data_in), .valid_in(valid_in),
        .frame_in(frame_in), .ready_in(ready_in), .clear_in(clear_in),
        .r_data_out(s_data), .r_valid_out(s_valid), .r_overrun_out(s_over),
        .r_frame_err_out(s_ferr)
    );

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_hunt[k]  = m_framed[k];
            m_nbits[k] = 0;
            m_acc[k]   = 0;
            m_valid[k] = 1'b0;
            m_data[k]  = 0;
            m_over[k]  = 1'b0;
            m_ferr[k]  = 1'b0;
        end
    endtask

    // Word-level reference: count bits received since the marker and build the value arithmetically.
    task automatic model_step(input bit d, input bit v, input bit f, input bit r, input bit c);
        bit complete;
        bit ferr_n;
        bit over_set;
        int word;
        for (int k = 0; k < 3; k++) begin
            complete = 1'b0;
            ferr_n   = 1'b0;
            word     = 0;
            if (v) begin
                if (m_framed[k] && f) begin
                    ferr_n     = !m_hunt[k] && (m_nbits[k] != 0);
                    m_hunt[k]  = 1'b0;
                    m_nbits[k] = 1;
                    m_acc[k]   = int'(d);
                end else if (!m_hunt[k]) begin
                    m_acc[k]   = m_acc[k] * 2 + int'(d);
                    m_nbits[k] = m_nbits[k] + 1;
                    if (m_nbits[k] == m_size[k]) begin
                        complete   = 1'b1;
                        word       = m_acc[k];
                        m_nbits[k] = 0;
                        m_acc[k]   = 0;
                    end
                end
            end
            over_set = complete && m_valid[k] && !r;
            if (complete && (!m_valid[k] || r)) begin
                m_data[k]  = word;
                m_valid[k] = 1'b1;
            end else if (m_valid[k] && r) begin
                m_valid[k] = 1'b0;
            end
            if (over_set) m_over[k] = 1'b1;
            else if (c)   m_over[k] = 1'b0;
            m_ferr[k] = ferr_n;
        end
    endtask

    task automatic checkOutput();
        check_val("f_data",  f_data,             8'(m_data[0]));
        check_val("f_valid", {7'b0, f_valid},    {7'b0, m_valid[0]});
        check_val("f_over",  {7'b0, f_over},     {7'b0, m_over[0]});
        check_val("f_ferr",  {7'b0, f_ferr},     {7'b0, m_ferr[0]});
        check_val("r_data",  r_data,             8'(m_data[1]));
        check_val("r_valid", {7'b0, r_valid},    {7'b0, m_valid[1]});
        check_val("r_over",  {7'b0, r_over},     {7'b0, m_over[1]});
        check_val("r_ferr",  {7'b0, r_ferr},     {7'b0, m_ferr[1]});
        check_val("s_data",  {6'b0, s_data},     8'(m_data[2]));
        check_val("s_valid", {7'b0, s_valid},    {7'b0, m_valid[2]});
        check_val("s_over",  {7'b0, s_over},     {7'b0, m_over[2]});
        check_val("s_ferr",  {7'b0, s_ferr},     {7'b0, m_ferr[2]});
    endtask

    task automatic applyStimulus(input bit d, input bit v, input bit f, input bit r, input bit c);
        data_in  = d;
        valid_in = v;
        frame_in = f;
        ready_in = r;
        clear_in = c;
        @(posedge clk_in);
        #1;
        model_step(d, v, f, r, c);
        checkOutput();
    endtask

    // Inputs are deliberately busy during reset to show reset overrides them.
    task automatic apply_reset();
        reset_in = 1'b1;
        data_in  = 1'b1;
        valid_in = 1'b1;
        frame_in = 1'b1;
        ready_in = 1'b0;
        clear_in = 1'b0;
        @(posedge clk_in);
        #1;
        reset_in = 1'b0;
        valid_in = 1'b0;
        frame_in = 1'b0;
        model_reset();
        checkOutput();
    endtask

    task automatic send_word(input logic [7:0] w, input bit mark, input bit gaps,
                             input bit r_body, input bit r_last);
        logic [7:0] wv;
        wv = w;
        for (int i = 7; i >= 0; i--) begin
            if (gaps && i != 7) begin
                repeat (i % 3) applyStimulus(1'b0, 1'b0, 1'b0, r_body, 1'b0);
            end
            applyStimulus(wv[i], 1'b1, mark && (i == 7), (i == 0) ? r_last : r_body, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] pat;
        reset_in = 1'b0;
        data_in  = 1'b0;
        valid_in = 1'b0;
        frame_in = 1'b0;
        ready_in = 1'b0;
        clear_in = 1'b0;
        model_reset();

        apply_reset();
        check_val("rst_f_count", {5'b0, dut_f.r_count}, 8'd7);
        check_val("rst_f_state", {7'b0, dut_f.state},   {7'b0, ST_HUNT});
        check_val("rst_r_state", {7'b0, dut_r.state},   {7'b0, ST_SHIFT});

        // Free-running receiver takes the first bit after reset as the MSB.
        pat = 8'hA5;
        for (int i = 7; i >= 0; i--) applyStimulus(pat[i], 1'b1, 1'b0, 1'b1, 1'b0);
        check_val("free_a5_data",  r_data,          8'hA5);
        check_val("free_a5_valid", {7'b0, r_valid}, 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("free_a5_drop",  {7'b0, r_valid}, 8'd0);

        send_word(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
        check_val("gaps_3c_data",  f_data,          8'h3C);
        check_val("gaps_3c_valid", {7'b0, f_valid}, 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        send_word(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("bp_data",  f_data,          8'hA5);
        check_val("bp_over",  {7'b0, f_over},  8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("bp_valid_fall", {7'b0, f_valid}, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("bp_clear", {7'b0, f_over}, 8'd0);

        send_word(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
        check_val("sim_data",  f_data,          8'h22);
        check_val("sim_valid", {7'b0, f_valid}, 8'd1);
        check_val("sim_over",  {7'b0, f_over},  8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Three bits of an abandoned word, then a fresh marker carrying 0x81.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        pat = 8'h81;
        applyStimulus(pat[7], 1'b1, 1'b1, 1'b1, 1'b0);
        check_val("resync_err", {7'b0, f_ferr}, 8'd1);
        applyStimulus(pat[6], 1'b1, 1'b0, 1'b1, 1'b0);
        check_val("resync_err_pulse", {7'b0, f_ferr}, 8'd0);
        for (int i = 5; i >= 0; i--) applyStimulus(pat[i], 1'b1, 1'b0, 1'b1, 1'b0);
        check_val("resync_data", f_data, 8'h81);

        pat = 8'h96;
        for (int i = 7; i >= 4; i--) applyStimulus(pat[i], 1'b1, i == 7, 1'b0, 1'b0);
        apply_reset();
        check_val("midrst_data",  f_data,                   8'h00);
        check_val("midrst_valid", {7'b0, f_valid},          8'd0);
        check_val("midrst_count", {5'b0, dut_f.r_count},    8'd7);
        check_val("midrst_state", {7'b0, dut_f.state},      {7'b0, ST_HUNT});
        send_word(8'hF0, 1'b1, 1'b0, 1'b1, 1'b1);
        check_val("midrst_f0", f_data, 8'hF0);

        // Two-bit word: marker bit then one more completes it.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_val("size2_data",  {6'b0, s_data},  8'd2);
        check_val("size2_valid", {7'b0, s_valid}, 8'd1);

        for (int n = 0; n < 400; n++) begin
            if (n == 200) apply_reset();
            applyStimulus(bit'($urandom_range(0, 1)),
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 15) == 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 7) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
- Serial-in/parallel-out receiver; the deserialising counterpart of the existing parallel-to-serial shifter on the stepper serial links.
- Assembles SIZE serial bits, MSB first, into one word.
- Presents each word on a valid/ready output stage.
- Optionally aligns to a start-of-word marker and flags framing errors and overruns.

Parameters:
- SIZE, 8, word width in bits (>= 2).
- FRAMED, 1: 1 = wait for frame_in before assembling and resync on it; 0 = free-running, first bit after reset is the MSB.

Ports:
- clk_in  input  1  single clock; all logic on its rising edge.
- reset_in  input  1  synchronous, active-high reset.
- data_in  input  1  serial data bit.
- valid_in  input  1  data_in is sampled on cycles where this is high.
- frame_in  input  1  marks the current valid bit as the word MSB. Ignored when FRAMED=0 or valid_in=0.
- ready_in  input  1  downstream accepts the word when r_valid_out and ready_in are both high.
- clear_in  input  1  clears r_overrun_out.
- r_data_out  output  SIZE  assembled word; held stable while r_valid_out=1.
- r_valid_out  output  1  word available.
- r_overrun_out  output  1  sticky; a completed word was dropped.
- r_frame_err_out  output  1  one-cycle pulse; frame_in arrived mid-word.

Behaviour:
- Reset values:
  - all outputs 0; shift register 0.
  - r_count = SIZE-1 (width $clog2(SIZE)).
  - state = HUNT if FRAMED=1, else SHIFT.
  - Reset has priority over every other input, including mid-word and mid-handshake; a partial word is discarded.
- States:
  - HUNT: valid_in & frame_in -> store bit at index SIZE-1, r_count = SIZE-2, go to SHIFT. Other bits are ignored.
  - SHIFT, normal bit: valid_in with no resync -> store data_in at index r_count.
    - If r_count != 0: r_count decrements.
    - If r_count == 0: the word completes and r_count reloads to SIZE-1. State stays SHIFT, so back-to-back words need no marker.
  - SHIFT, resync (FRAMED=1 only): valid_in & frame_in & r_count != SIZE-1.
    - Pulse r_frame_err_out for 1 cycle.
    - Discard the partial word.
    - Treat this bit as the new MSB: stored at index SIZE-1, r_count = SIZE-2.
  - SHIFT, frame_in at r_count == SIZE-1: normal, no error.
  - valid_in=0: the state machine holds; gaps of any length are allowed.
- Completion:
  - The completed word is the shift register with the final bit merged in combinationally.
  - Latency: r_data_out and r_valid_out update on the clock edge that samples the final bit, i.e. visible the cycle after the final valid bit.
- Output handshake:
  - r_valid_out rises on completion. It stays high until a cycle with ready_in=1, then falls on the next edge, unless a new word completes in that same cycle.
  - Completion while r_valid_out=0, or while r_valid_out=1 & ready_in=1: load r_data_out, r_valid_out = 1. The simultaneous accept-and-load case runs back-to-back with no bubble.
  - Completion while r_valid_out=1 & ready_in=0: the new word is dropped, r_data_out is unchanged, r_overrun_out is set.
  - ready_in while r_valid_out=0: no effect.
- Overrun flag:
  - r_overrun_out stays set until clear_in or reset.
  - A clear_in and a new overrun in the same cycle leave the flag set; set wins.
- SIZE=2 boundary: count width is 1. The word completes on every second valid bit.

Decomposition:
- Shared package:
  - state encoding constants ST_HUNT=1'b0, ST_SHIFT=1'b1.
  - a count-width constant/function shared with the transmitter, so both ends size their counters identically.
- Sub-module sipo_out_stage: the one-entry valid/ready holding register, including overrun and clear logic. It is reused by future deserialisers.
- Bit counter and FSM stay inline.

Test Plan:
- Free-running: FRAMED=0, SIZE=8, ready_in=1. Bits 1,0,1,0,0,1,0,1 with valid_in=1 each cycle -> r_data_out=8'hA5, r_valid_out=1 one cycle after bit 8, low the next cycle.
- Gaps: FRAMED=1. frame_in with the first bit of 0x3C, then valid_in toggled 1,0,0,1 irregularly -> 8'h3C, with no r_frame_err_out.
- Backpressure and overrun: ready_in=0, send 0xA5 then 0x3C -> r_data_out stays 0xA5, r_overrun_out=1. Then ready_in=1 -> valid falls. Then clear_in -> r_overrun_out=0.
- Simultaneous accept and complete: word 0x11 pending, ready_in=1 on the cycle 0x22 completes -> next cycle r_data_out=0x22, r_valid_out stays 1, no overrun.
- Resync: FRAMED=1, 3 bits of a word, then frame_in followed by bits of 0x81 -> one-cycle r_frame_err_out on the frame_in cycle, output 0x81.
- Reset mid-word: 4 bits in, reset_in for 1 cycle -> all outputs 0, r_count=7, HUNT. A subsequent framed 0xF0 is received correctly.
